// File: rtl/vrb_pkg.sv
// Shared types for the VRB data-RAM responder.
// State encoding, wait counter width, lane helper.
package vrb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RSP
  } vrb_state_t;

  localparam int VRB_WAIT_W = 4;

  function automatic int vrb_lanes(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/vrb_ram_core.sv
// Word RAM, per-byte write enable, registered read.
// Ports: clk, en, we, idx, wdata, wmask -> rdata.
module vrb_ram_core
  import vrb_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 1024
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [DW-1:0]            wdata,
  input  logic [DW/8-1:0]          wmask,
  output logic [DW-1:0]            rdata
);

  localparam int NL = vrb_lanes(DW);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < NL; i++) begin
          if (wmask[i]) begin
            mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
          end
        end
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/vrb_ram_slave.sv
// VRB responder: windowed data RAM with wait states.
// Ports: clk, rst_n, i_vrb_cmd_*, o_vrb_rsp_*. Option: VRB_RAM_ALIGN_CHK_EN.
module vrb_ram_slave
  import vrb_pkg::*;
#(
  parameter int            AW          = 32,
  parameter int            DW          = 32,
  parameter int            DEPTH       = 1024,
  parameter logic [AW-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int            WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_vrb_cmd_valid,
  input  logic [AW-1:0]   i_vrb_cmd_addr,
  input  logic            i_vrb_cmd_read,
  input  logic [DW-1:0]   i_vrb_cmd_wdata,
  input  logic [DW/8-1:0] i_vrb_cmd_wmask,
  output logic            o_vrb_rsp_valid,
  output logic            o_vrb_rsp_err,
  output logic [DW-1:0]   o_vrb_rsp_rdata
);

  localparam int NL = vrb_lanes(DW);
  localparam int LB = $clog2(NL);
  localparam int IW = $clog2(DEPTH);
  localparam logic [AW-1:0] WIN = AW'(DEPTH * NL);
  localparam logic [VRB_WAIT_W-1:0] WC = VRB_WAIT_W'(WAIT_CYCLES);
  localparam logic [VRB_WAIT_W-1:0] ONE = VRB_WAIT_W'(1);
  localparam bit NOWAIT = (WAIT_CYCLES == 0);

  vrb_state_t            state;
  logic [VRB_WAIT_W-1:0] cnt;
  logic [AW-1:0]         addr_q;
  logic                  read_q;
  logic [DW-1:0]         wdata_q;
  logic [NL-1:0]         wmask_q;
  logic                  rsp_v_q;
  logic                  rsp_err_q;
  logic                  rsp_rd_q;

  logic                  is_idle;
  logic [AW-1:0]         c_addr;
  logic                  c_read;
  logic [DW-1:0]         c_wdata;
  logic [NL-1:0]         c_wmask;
  logic [AW-1:0]         off;
  logic                  hit;
  logic                  bad;
  logic                  ok;
  logic                  go_rsp;
  logic [DW-1:0]         core_rdata;

  // With no wait states the RAM is accessed on the accept edge itself,
  // so the live command is used; otherwise the latched copy.
  assign is_idle = (state == IDLE);
  assign c_addr  = is_idle ? i_vrb_cmd_addr  : addr_q;
  assign c_read  = is_idle ? i_vrb_cmd_read  : read_q;
  assign c_wdata = is_idle ? i_vrb_cmd_wdata : wdata_q;
  assign c_wmask = is_idle ? i_vrb_cmd_wmask : wmask_q;

  // Unsigned offset compare: addresses below the base wrap high and miss.
  assign off = c_addr - BASE_ADDR;
  assign hit = (off < WIN);

`ifdef VRB_RAM_ALIGN_CHK_EN
  assign bad = (|c_addr[LB-1:0]) || (!c_read && (c_wmask == '0));
`else
  assign bad = 1'b0;
`endif

  assign ok = hit && !bad;

  // Gated by rst_n so a command held during reset never writes.
  assign go_rsp = rst_n &&
    ((is_idle && i_vrb_cmd_valid && NOWAIT) ||
     ((state == WAIT) && (cnt == ONE)));

  vrb_ram_core #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_core (
    .clk   (clk),
    .en    (go_rsp && ok),
    .we    (!c_read),
    .idx   (c_addr[IW+LB-1:LB]),
    .wdata (c_wdata),
    .wmask (c_wmask),
    .rdata (core_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      read_q    <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      rsp_v_q   <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_rd_q  <= 1'b0;
    end else begin
      rsp_v_q   <= go_rsp;
      rsp_err_q <= go_rsp && !ok;
      rsp_rd_q  <= go_rsp && ok && c_read;
      unique case (state)
        IDLE: begin
          if (i_vrb_cmd_valid) begin
            addr_q  <= i_vrb_cmd_addr;
            read_q  <= i_vrb_cmd_read;
            wdata_q <= i_vrb_cmd_wdata;
            wmask_q <= i_vrb_cmd_wmask;
            if (NOWAIT) begin
              state <= RSP;
            end else begin
              state <= WAIT;
              cnt   <= WC;
            end
          end
        end
        WAIT: begin
          cnt <= cnt - ONE;
          if (cnt == ONE) state <= RSP;
        end
        RSP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign o_vrb_rsp_valid = rsp_v_q;
  assign o_vrb_rsp_err   = rsp_err_q;
  assign o_vrb_rsp_rdata = rsp_rd_q ? core_rdata : '0;

endmodule

// File: tb/tb_vrb_ram_slave.sv
// Scoreboard bench: one instance with no wait states, one with three.
// Expected err/rdata/response cycle queued at issue, checked by a monitor.
module tb_vrb_ram_slave;

  typedef struct {
    logic        err;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vld [2];
  logic [31:0] addr [2];
  logic        rd [2];
  logic [31:0] wd [2];
  logic [3:0]  wm [2];
  logic        rv [2];
  logic        re [2];
  logic [31:0] rdat [2];

  exp_t q0 [$];
  exp_t q1 [$];
  int   free [2];
  int   wc [2];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  vrb_ram_slave #(.WAIT_CYCLES(0)) u0 (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_vrb_cmd_valid (vld[0]),
    .i_vrb_cmd_addr  (addr[0]),
    .i_vrb_cmd_read  (rd[0]),
    .i_vrb_cmd_wdata (wd[0]),
    .i_vrb_cmd_wmask (wm[0]),
    .o_vrb_rsp_valid (rv[0]),
    .o_vrb_rsp_err   (re[0]),
    .o_vrb_rsp_rdata (rdat[0])
  );

  vrb_ram_slave #(.WAIT_CYCLES(3)) u3 (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_vrb_cmd_valid (vld[1]),
    .i_vrb_cmd_addr  (addr[1]),
    .i_vrb_cmd_read  (rd[1]),
    .i_vrb_cmd_wdata (wd[1]),
    .i_vrb_cmd_wmask (wm[1]),
    .o_vrb_rsp_valid (rv[1]),
    .o_vrb_rsp_err   (re[1]),
    .o_vrb_rsp_rdata (rdat[1])
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic mon(input int u, input exp_t e);
    chk($sformatf("u%0d err", u), 32'(re[u]), 32'(e.err));
    chk($sformatf("u%0d rdata", u), rdat[u], e.data);
    chk($sformatf("u%0d rsp cycle", u), cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int u = 0; u < 2; u++) begin
        if (rv[u]) begin
          if ((u == 0 ? q0.size() : q1.size()) == 0) begin
            checks++;
            errors++;
            $display("FAIL u%0d spurious rsp at cycle %0d expected none",
                     u, cyc);
          end else if (u == 0) begin
            mon(0, q0.pop_front());
          end else begin
            mon(1, q1.pop_front());
          end
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge where the response shows.
  // Valid stays high so a following call is back-to-back.
  task automatic issue(input int u, input logic [31:0] a, input logic r,
                       input logic [31:0] d, input logic [3:0] m,
                       input logic e_err, input logic [31:0] e_data);
    int   acc;
    exp_t e;
    vld[u]  = 1'b1;
    addr[u] = a;
    rd[u]   = r;
    wd[u]   = d;
    wm[u]   = m;
    acc = (cyc + 1 > free[u]) ? cyc + 1 : free[u];
    e.err  = e_err;
    e.data = e_data;
    e.cyc  = acc + wc[u];
    if (u == 0) q0.push_back(e);
    else q1.push_back(e);
    free[u] = acc + wc[u] + 2;
    while (cyc < acc + wc[u]) @(negedge clk);
  endtask

  task automatic drop(input int u);
    vld[u] = 1'b0;
    @(negedge clk);
  endtask

  task automatic rd_any(input int u, input logic [31:0] a,
                        input logic e_err, input logic [31:0] e_data);
    issue(u, a, 1'b1, 32'h0, 4'h0, e_err, e_data);
  endtask

  task automatic wr(input int u, input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] m, input logic e_err);
    issue(u, a, 1'b0, d, m, e_err, 32'h0);
  endtask

  initial begin
    wc[0] = 0;
    wc[1] = 3;
    for (int u = 0; u < 2; u++) begin
      vld[u]  = 1'b1;
      addr[u] = 32'h8000_0020;
      rd[u]   = 1'b0;
      wd[u]   = 32'h1111_1111;
      wm[u]   = 4'hF;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("reset u%0d valid", u), 32'(rv[u]), 32'h0);
      chk($sformatf("reset u%0d rdata", u), rdat[u], 32'h0);
    end
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    free[0] = cyc + 1;
    free[1] = cyc + 1;

    wr(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0);
    drop(0);
    rd_any(0, 32'h8000_0010, 1'b0, 32'hDEAD_BEEF);
    wr(0, 32'h8000_0010, 32'h0000_5500, 4'b0010, 1'b0);
    rd_any(0, 32'h8000_0010, 1'b0, 32'hDEAD_55EF);
    wr(0, 32'h8000_0000, 32'h1234_5678, 4'hF, 1'b0);
`ifdef VRB_RAM_ALIGN_CHK_EN
    rd_any(0, 32'h8000_0002, 1'b1, 32'h0);
    wr(0, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 1'b1);
`else
    rd_any(0, 32'h8000_0002, 1'b0, 32'h1234_5678);
    wr(0, 32'h8000_0000, 32'hFFFF_FFFF, 4'h0, 1'b0);
`endif
    rd_any(0, 32'h8000_0000, 1'b0, 32'h1234_5678);
    rd_any(0, 32'h7FFF_FFFC, 1'b1, 32'h0);
    wr(0, 32'h8000_1000, 32'h5555_5555, 4'hF, 1'b1);
    wr(0, 32'hFFFF_FFFC, 32'h6666_6666, 4'hF, 1'b1);
    wr(0, 32'h8000_0FFC, 32'hA5A5_A5A5, 4'hF, 1'b0);
    rd_any(0, 32'h8000_0FFC, 1'b0, 32'hA5A5_A5A5);
    rd_any(0, 32'h8000_0000, 1'b0, 32'h1234_5678);
    drop(0);

    wr(1, 32'h8000_0040, 32'h0BAD_F00D, 4'hF, 1'b0);
    rd_any(1, 32'h8000_0040, 1'b0, 32'h0BAD_F00D);
    rd_any(1, 32'h6000_0000, 1'b1, 32'h0);
    wr(1, 32'h8000_0040, 32'h00C0_0000, 4'b0100, 1'b0);
    rd_any(1, 32'h8000_0040, 1'b0, 32'h0BC0_F00D);
    drop(1);
    repeat (2) @(negedge clk);

    // Reset with u3 mid-wait on a write and u0 holding a write.
    vld[1]  = 1'b1;
    addr[1] = 32'h8000_0040;
    rd[1]   = 1'b0;
    wd[1]   = 32'hFFFF_FFFF;
    wm[1]   = 4'hF;
    repeat (2) @(negedge clk);
    rst_n   = 1'b0;
    vld[0]  = 1'b1;
    addr[0] = 32'h8000_0010;
    rd[0]   = 1'b0;
    wd[0]   = 32'h1111_1111;
    wm[0]   = 4'hF;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("midreset u%0d valid", u), 32'(rv[u]), 32'h0);
    end
    vld[0] = 1'b0;
    vld[1] = 1'b0;
    rst_n  = 1'b1;
    @(negedge clk);
    free[0] = cyc + 1;
    free[1] = cyc + 1;
    rd_any(0, 32'h8000_0010, 1'b0, 32'hDEAD_55EF);
    drop(0);
    rd_any(1, 32'h8000_0040, 1'b0, 32'h0BC0_F00D);
    drop(1);

    repeat (8) @(negedge clk);
    chk("u0 pending rsp", 32'(q0.size()), 32'h0);
    chk("u3 pending rsp", 32'(q1.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
